// File: rtl/exotiny_console_pkg.sv
// exotiny_console_pkg: register map, STATUS layout, magic sequences and TX states for the console
package exotiny_console_pkg;
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_DONE  = 3;
  localparam int ST_ERR   = 4;
  localparam int ST_OVF   = 5;
  localparam int ST_LVL   = 8;
  localparam logic [31:0] SEQ_DONE = 32'h444F4E45;
  localparam logic [23:0] SEQ_ERR  = 24'h455252;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
endpackage

// File: rtl/exotiny_sync_fifo.sv
// exotiny_sync_fifo: show-ahead synchronous FIFO; a push on a full FIFO is taken when a pop frees the slot
module exotiny_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_level;
  logic             w_do_push, w_do_pop;

  assign o_full    = r_level == (AW+1)'(DEPTH);
  assign o_empty   = r_level == '0;
  assign o_level   = r_level;
  assign o_data    = r_mem[r_rd];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk_i or negedge rst_in)
    if (!rst_in) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop) r_rd <= r_rd + AW'(1);
      r_level <= r_level + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end

  always_ff @(posedge clk_i)
    if (w_do_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/exotiny_console_tx.sv
// exotiny_console_tx: Wishbone console port that queues bytes for an 8N1 UART
// and flags the DONE/ERR termination strings seen in the written stream.
module exotiny_console_tx
  import exotiny_console_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int DIV_RST    = 434
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        tx_o,
  output logic        done_o,
  output logic        err_o
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic             r_ack, r_done, r_err, r_ovf, r_tx, r_hist_upd;
  logic [31:0]      r_dat, r_hist;
  logic [DIV_W-1:0] r_div, r_div_lat, r_cnt;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit;
  tx_state_e        r_state, w_next;
  logic             w_acc, w_wr, w_tx_wr, w_stat_wr, w_div_wr, w_set_done, w_set_err;
  logic             w_pop, w_full, w_empty, w_tick, w_tx_bit, w_busy, w_unused;
  logic [1:0]       w_reg;
  logic [7:0]       w_head;
  logic [LW-1:0]    w_level;
  logic [31:0]      w_status, w_rd;
  logic [DIV_W-1:0] w_div_in;

  assign w_reg      = wb_adr_i[3:2];
  assign w_acc      = wb_stb_i && !r_ack;
  assign w_wr       = w_acc && wb_we_i && wb_sel_i[0];
  assign w_tx_wr    = w_wr && (w_reg == REG_TXDATA);
  assign w_stat_wr  = w_wr && (w_reg == REG_STATUS);
  assign w_div_wr   = w_wr && (w_reg == REG_BAUDDIV);
  assign w_div_in   = wb_dat_i[DIV_W-1:0];
  assign w_set_done = r_hist_upd && (r_hist == SEQ_DONE);
  assign w_set_err  = r_hist_upd && (r_hist[23:0] == SEQ_ERR);
  assign w_tick     = r_cnt == DIV_W'(1);
  assign w_unused   = ^{wb_sel_i[3:1], wb_adr_i[1:0], wb_dat_i[31:8]};

  exotiny_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_in  (rst_in),
    .i_push  (w_tx_wr),
    .i_data  (wb_dat_i[7:0]),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_comb begin
    w_status            = '0;
    w_status[ST_FULL]   = w_full;
    w_status[ST_EMPTY]  = w_empty;
    w_status[ST_BUSY]   = w_busy;
    w_status[ST_DONE]   = r_done;
    w_status[ST_ERR]    = r_err;
    w_status[ST_OVF]    = r_ovf;
    w_status[ST_LVL+:8] = 8'(w_level);
    w_rd = (w_reg == REG_STATUS) ? w_status : (w_reg == REG_BAUDDIV) ? 32'(r_div) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_in)
    if (!rst_in) begin
      r_ack <= 1'b0;
      r_dat <= '0;
      r_div <= DIV_W'(DIV_RST);
    end else begin
      r_ack <= w_acc;
      r_dat <= (w_acc && !wb_we_i) ? w_rd : '0;
      if (w_div_wr) r_div <= (w_div_in == '0) ? DIV_W'(1) : w_div_in;
    end

  // flags are evaluated the cycle after the history shift; a set beats a same-cycle clear
  always_ff @(posedge clk_i or negedge rst_in)
    if (!rst_in) begin
      r_hist     <= '0;
      r_hist_upd <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_hist_upd <= w_tx_wr;
      if (w_tx_wr) r_hist <= {r_hist[23:0], wb_dat_i[7:0]};
      r_done <= w_set_done || (r_done && !w_stat_wr);
      r_err  <= w_set_err || (r_err && !w_stat_wr);
      r_ovf  <= (w_tx_wr && w_full && !w_pop) || (r_ovf && !w_stat_wr);
    end

  always_ff @(posedge clk_i or negedge rst_in)
    if (!rst_in) r_state <= TX_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      TX_IDLE:  w_next = w_empty ? TX_IDLE : TX_START;
      TX_START: w_next = w_tick ? TX_DATA : TX_START;
      TX_DATA:  w_next = (w_tick && r_bit == 3'd7) ? TX_STOP : TX_DATA;
      default:  w_next = w_tick ? TX_IDLE : TX_STOP;
    endcase
  end

  always_comb begin
    w_pop    = (r_state == TX_IDLE) && !w_empty;
    w_busy   = r_state != TX_IDLE;
    w_tx_bit = (r_state == TX_START) ? 1'b0 : (r_state == TX_DATA) ? r_shift[0] : 1'b1;
  end

  // divisor is latched per frame so a mid-frame BAUDDIV write only affects the next frame
  always_ff @(posedge clk_i or negedge rst_in)
    if (!rst_in) begin
      r_tx      <= 1'b1;
      r_cnt     <= '0;
      r_div_lat <= '0;
      r_shift   <= '0;
      r_bit     <= '0;
    end else begin
      r_tx <= w_tx_bit;
      if (w_pop) begin
        r_shift   <= w_head;
        r_cnt     <= r_div;
        r_div_lat <= r_div;
        r_bit     <= '0;
      end else if (w_busy) begin
        r_cnt <= w_tick ? r_div_lat : r_cnt - DIV_W'(1);
        if (w_tick && r_state == TX_DATA) begin
          r_shift <= r_shift >> 1;
          r_bit   <= r_bit + 3'd1;
        end
      end
    end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign tx_o     = r_tx;
  assign done_o   = r_done;
  assign err_o    = r_err;
endmodule
